// File: rtl/mau_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mau_pkg
// Brief    : Shared opcodes, funct3 codes, access sizes and FSM states.
// Revision : 1.0
// ============================================================================
package mau_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        DONE = 2'd2
    } state_t;

    // An access is misaligned when any address bit below its natural size is set.
    function automatic logic is_misaligned(input logic [2:0] off, input msize_t size);
        logic [2:0] mask;
        case (size)
            MSIZE1:  mask = 3'b000;
            MSIZE2:  mask = 3'b001;
            MSIZE4:  mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return |(off & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Brief    : Byte-lane steering for stores and extraction/extension for loads.
// Revision : 1.0
// ============================================================================
module mem_lane_align
    import mau_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      off,
    input  msize_t          size,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_data,
    input  logic            is_unsigned,
    output logic [7:0]      strobe,
    output logic [XLEN-1:0] store_shifted,
    output logic [XLEN-1:0] load_ext
);

    logic [7:0]      byte_mask;
    logic [XLEN-1:0] raw;
    logic            sx;

    always_comb begin
        case (size)
            MSIZE1:  byte_mask = 8'h01;
            MSIZE2:  byte_mask = 8'h03;
            MSIZE4:  byte_mask = 8'h0F;
            default: byte_mask = 8'hFF;
        endcase
        strobe        = byte_mask << off;
        store_shifted = store_data << {off, 3'b000};
    end

    // Load data arrives 8-byte aligned; shift the addressed byte down to lane 0.
    always_comb begin
        raw = load_data >> {off, 3'b000};
        sx  = ~is_unsigned;
        case (size)
            MSIZE1:  load_ext = {{(XLEN-8){sx & raw[7]}}, raw[7:0]};
            MSIZE2:  load_ext = {{(XLEN-16){sx & raw[15]}}, raw[15:0]};
            MSIZE4:  load_ext = {{(XLEN-32){sx & raw[31]}}, raw[31:0]};
            default: load_ext = raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Turns ALU results into bus loads/stores or pass-through writebacks.
// Revision : 1.0
// ============================================================================
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_result,
    input  logic [XLEN-1:0]   in_store_data,
    input  logic [REG_AW-1:0] in_rd,
    output logic              dreq_valid,
    output logic              dreq_write,
    output logic [XLEN-1:0]   dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [XLEN-1:0]   dreq_data,
    input  logic              dresp_ok,
    input  logic [XLEN-1:0]   dresp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wen,
    output logic [XLEN-1:0]   out_data,
    output logic              out_misalign
);

    state_t            state_q, state_d;
    logic [6:0]        opcode_q, opcode_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   sdata_q, sdata_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic              out_wen_q, out_wen_d;
    logic              out_misalign_q, out_misalign_d;

    logic              in_is_mem;
    logic              in_misaligned;
    logic              is_load_q;
    logic              is_store_q;
    logic              in_mem;
    logic [7:0]        lane_strobe;
    logic [XLEN-1:0]   lane_sdata;
    logic [XLEN-1:0]   lane_ldata;

    assign in_is_mem     = (in_opcode == OP_LOAD) || (in_opcode == OP_STORE);
    assign in_misaligned = is_misaligned(in_result[2:0], msize_t'(in_funct3[1:0]));
    assign is_load_q     = (opcode_q == OP_LOAD);
    assign is_store_q    = (opcode_q == OP_STORE);
    assign in_mem        = (state_q == MEM);

    mem_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .off           (addr_q[2:0]),
        .size          (msize_t'(funct3_q[1:0])),
        .store_data    (sdata_q),
        .load_data     (dresp_data),
        .is_unsigned   (funct3_q[2]),
        .strobe        (lane_strobe),
        .store_shifted (lane_sdata),
        .load_ext      (lane_ldata)
    );

    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        funct3_d       = funct3_q;
        addr_d         = addr_q;
        sdata_d        = sdata_q;
        rd_d           = rd_q;
        out_data_d     = out_data_q;
        out_wen_d      = out_wen_q;
        out_misalign_d = out_misalign_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opcode_d       = in_opcode;
                    funct3_d       = in_funct3;
                    addr_d         = in_result;
                    sdata_d        = in_store_data;
                    rd_d           = in_rd;
                    out_data_d     = '0;
                    out_wen_d      = 1'b0;
                    out_misalign_d = 1'b0;
                    if (!in_is_mem) begin
                        state_d    = DONE;
                        out_data_d = in_result;
                        out_wen_d  = (in_rd != '0);
                    end else if (in_misaligned) begin
                        state_d        = DONE;
                        out_misalign_d = 1'b1;
                    end else begin
                        state_d = MEM;
                    end
                end
            end
            MEM: begin
                if (dresp_ok) begin
                    state_d = DONE;
                    if (is_load_q) begin
                        out_data_d = lane_ldata;
                        out_wen_d  = (rd_q != '0);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            opcode_q       <= '0;
            funct3_q       <= '0;
            addr_q         <= '0;
            sdata_q        <= '0;
            rd_q           <= '0;
            out_data_q     <= '0;
            out_wen_q      <= 1'b0;
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            funct3_q       <= funct3_d;
            addr_q         <= addr_d;
            sdata_q        <= sdata_d;
            rd_q           <= rd_d;
            out_data_q     <= out_data_d;
            out_wen_q      <= out_wen_d;
            out_misalign_q <= out_misalign_d;
        end
    end

    // Bus fields are only driven while a request is outstanding.
    assign in_ready     = (state_q == IDLE);
    assign dreq_valid   = in_mem;
    assign dreq_write   = in_mem & is_store_q;
    assign dreq_addr    = in_mem ? addr_q : '0;
    assign dreq_size    = in_mem ? {1'b0, funct3_q[1:0]} : 3'd0;
    assign dreq_strobe  = (in_mem && is_store_q) ? lane_strobe : 8'h00;
    assign dreq_data    = (in_mem && is_store_q) ? lane_sdata : '0;

    assign out_valid    = (state_q == DONE);
    assign out_rd       = rd_q;
    assign out_wen      = out_wen_q;
    assign out_data     = out_data_q;
    assign out_misalign = out_misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Vector table with a writeback scoreboard plus reset/back-pressure runs.
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

    localparam logic [6:0] OPL = 7'b0000011;
    localparam logic [6:0] OPS = 7'b0100011;
    localparam logic [6:0] OPR = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [63:0] in_result;
    logic [63:0] in_store_data;
    logic [4:0]  in_rd;
    logic        dreq_valid;
    logic        dreq_write;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_ok;
    logic [63:0] dresp_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [63:0] out_data;
    logic        out_misalign;

    always #5 clk = ~clk;

    mem_access_unit #(
        .XLEN   (64),
        .REG_AW (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_funct3     (in_funct3),
        .in_result     (in_result),
        .in_store_data (in_store_data),
        .in_rd         (in_rd),
        .dreq_valid    (dreq_valid),
        .dreq_write    (dreq_write),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_ok      (dresp_ok),
        .dresp_data    (dresp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rd        (out_rd),
        .out_wen       (out_wen),
        .out_data      (out_data),
        .out_misalign  (out_misalign)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [63:0] res;
        logic [63:0] sd;
        logic [4:0]  rd;
        int          wait_n;
        logic [63:0] resp;
        logic        exp_mem;
        logic        exp_write;
        logic [7:0]  exp_strb;
        logic [63:0] exp_dq;
        logic [63:0] exp_out;
        logic        chk_out;
        logic        exp_wen;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(
        input logic [6:0] op, input logic [2:0] f3, input logic [63:0] res,
        input logic [63:0] sd, input logic [4:0] rd, input int wn,
        input logic [63:0] resp, input logic em, input logic ew,
        input logic [7:0] strb, input logic [63:0] dq, input logic [63:0] eo,
        input logic co, input logic wen, input logic mis);
        vec_t v;
        v.op = op; v.f3 = f3; v.res = res; v.sd = sd; v.rd = rd; v.wait_n = wn;
        v.resp = resp; v.exp_mem = em; v.exp_write = ew; v.exp_strb = strb;
        v.exp_dq = dq; v.exp_out = eo; v.chk_out = co; v.exp_wen = wen; v.exp_mis = mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc;
        int   waits;
        bit   saw_req;
        bit   done_flag;
        vec_t e;
        @(negedge clk);
        chk("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_opcode = v.op; in_funct3 = v.f3; in_result = v.res;
        in_store_data = v.sd; in_rd = v.rd; dresp_data = v.resp;
        sb.push_back(v);
        n_vec++;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1; waits = 0; saw_req = 1'b0; done_flag = 1'b0;
        while (!done_flag && cyc < 40) begin
            dresp_ok = 1'b0;
            if (dreq_valid) begin
                chk("dreq_addr", dreq_addr, v.res);
                if (!saw_req) begin
                    saw_req = 1'b1;
                    chk("dreq_valid_expected", {63'd0, dreq_valid}, {63'd0, v.exp_mem});
                    chk("dreq_write", {63'd0, dreq_write}, {63'd0, v.exp_write});
                    chk("dreq_size", {61'd0, dreq_size}, {61'd0, 1'b0, v.f3[1:0]});
                    chk("dreq_strobe", {56'd0, dreq_strobe}, {56'd0, v.exp_strb});
                    chk("dreq_data", dreq_data, v.exp_dq);
                end
                if (waits == v.wait_n) dresp_ok = 1'b1;
                else waits++;
            end
            if (out_valid) begin
                e = sb.pop_front();
                chk("latency", 64'(cyc), e.exp_mem ? 64'(2 + e.wait_n) : 64'd1);
                chk("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
                chk("out_wen", {63'd0, out_wen}, {63'd0, e.exp_wen});
                chk("out_misalign", {63'd0, out_misalign}, {63'd0, e.exp_mis});
                if (e.chk_out) chk("out_data", out_data, e.exp_out);
                chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                chk("idle_after_handoff", {62'd0, in_ready, out_valid}, 64'd2);
                done_flag = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        dresp_ok = 1'b0;
        if (!done_flag) begin
            n_fail++;
            $display("FAIL timeout: no out_valid for op 0x%0h addr 0x%0h", v.op, v.res);
            void'(sb.pop_front());
        end
        chk("dreq_seen", {63'd0, saw_req}, {63'd0, v.exp_mem});
    endtask

    initial begin
        int   budget;
        logic [63:0] held;

        reset = 1'b0; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_result = '0;
        in_store_data = '0; in_rd = '0; dresp_ok = 1'b0; dresp_data = '0; out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_flags", {59'd0, dreq_valid, dreq_write, out_valid, out_wen, out_misalign}, 64'd0);
        chk("reset_out_data", out_data, 64'd0);
        chk("reset_strobe_size", {53'd0, dreq_strobe, dreq_size}, 64'd0);
        reset = 1'b1;

        vecs.push_back(mk(OPR, 3'b000, 64'h1234, 64'h0, 5'd5, 0, 64'h0, 0, 0, 8'h00, 64'h0, 64'h1234, 1, 1, 0));
        vecs.push_back(mk(OPL, 3'b000, 64'h1003, 64'h0, 5'd7, 3, 64'h0000_0000_8000_0000, 1, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1, 1, 0));
        vecs.push_back(mk(OPL, 3'b100, 64'h1003, 64'h0, 5'd7, 3, 64'h0000_0000_8000_0000, 1, 0, 8'h00, 64'h0, 64'h80, 1, 1, 0));
        vecs.push_back(mk(OPS, 3'b001, 64'h2006, 64'hABCD, 5'd9, 0, 64'h0, 1, 1, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0, 0, 0, 0));
        vecs.push_back(mk(OPL, 3'b010, 64'h3002, 64'h0, 5'd4, 0, 64'h0, 0, 0, 8'h00, 64'h0, 64'h0, 0, 0, 1));
        vecs.push_back(mk(OPR, 3'b000, 64'hDEAD, 64'h0, 5'd0, 0, 64'h0, 0, 0, 8'h00, 64'h0, 64'hDEAD, 1, 0, 0));
        vecs.push_back(mk(OPL, 3'b011, 64'h4000, 64'h0, 5'd1, 0, 64'h8877_6655_4433_2211, 1, 0, 8'h00, 64'h0, 64'h8877_6655_4433_2211, 1, 1, 0));
        vecs.push_back(mk(OPL, 3'b001, 64'h10A6, 64'h0, 5'd2, 1, 64'h8001_0000_0000_0000, 1, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1, 1, 0));
        vecs.push_back(mk(OPL, 3'b101, 64'h10A6, 64'h0, 5'd2, 1, 64'h8001_0000_0000_0000, 1, 0, 8'h00, 64'h0, 64'h8001, 1, 1, 0));
        vecs.push_back(mk(OPL, 3'b110, 64'h5004, 64'h0, 5'd3, 2, 64'hF000_0000_1234_5678, 1, 0, 8'h00, 64'h0, 64'h0000_0000_F000_0000, 1, 1, 0));
        vecs.push_back(mk(OPL, 3'b010, 64'h5004, 64'h0, 5'd3, 2, 64'hF000_0000_1234_5678, 1, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_F000_0000, 1, 1, 0));
        vecs.push_back(mk(OPL, 3'b011, 64'h6000, 64'h0, 5'd0, 0, 64'hCAFE, 1, 0, 8'h00, 64'h0, 64'hCAFE, 1, 0, 0));
        vecs.push_back(mk(OPS, 3'b011, 64'h7000, 64'h0123_4567_89AB_CDEF, 5'd3, 1, 64'h0, 1, 1, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 0));
        vecs.push_back(mk(OPS, 3'b000, 64'h7005, 64'hFFFF_FF5A, 5'd3, 0, 64'h0, 1, 1, 8'h20, 64'hFFFF_5A00_0000_0000, 64'h0, 0, 0, 0));
        vecs.push_back(mk(OPS, 3'b010, 64'h7001, 64'h55, 5'd3, 0, 64'h0, 0, 0, 8'h00, 64'h0, 64'h0, 0, 0, 1));
        vecs.push_back(mk(OPL, 3'b111, 64'h8000, 64'h0, 5'd6, 0, 64'h8000_0000_0000_0001, 1, 0, 8'h00, 64'h0, 64'h8000_0000_0000_0001, 1, 1, 0));
        vecs.push_back(mk(OPL, 3'b001, 64'h9002, 64'h0, 5'd6, 0, 64'h0000_0000_FEDC_0000, 1, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FEDC, 1, 1, 0));
        vecs.push_back(mk(OPL, 3'b001, 64'h9001, 64'h0, 5'd6, 0, 64'h0, 0, 0, 8'h00, 64'h0, 64'h0, 0, 0, 1));
        vecs.push_back(mk(OPI, 3'b000, 64'h3, 64'h0, 5'd8, 0, 64'h0, 0, 0, 8'h00, 64'h0, 64'h3, 1, 1, 0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-pressure: LD completes, writeback stalls for 4 cycles.
        n_vec++;
        @(negedge clk);
        in_valid = 1'b1; in_opcode = OPL; in_funct3 = 3'b011; in_result = 64'h4008;
        in_rd = 5'd12; dresp_data = 64'h1122_3344_5566_7788;
        @(negedge clk);
        in_valid = 1'b0;
        budget = 0;
        while (!dreq_valid && budget < 20) begin @(negedge clk); budget++; end
        chk("bp_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        dresp_ok = 1'b1;
        @(negedge clk);
        dresp_ok = 1'b0;
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        held = out_data;
        chk("bp_out_data", held, 64'h1122_3344_5566_7788);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_hold_valid_ready", {62'd0, out_valid, in_ready}, 64'd2);
            chk("bp_hold_data", out_data, 64'h1122_3344_5566_7788);
            chk("bp_hold_rd_wen", {58'd0, out_rd, out_wen}, {58'd0, 5'd12, 1'b1});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_after", {62'd0, in_ready, out_valid}, 64'd2);

        // Reset while a request is outstanding.
        n_vec++;
        @(negedge clk);
        in_valid = 1'b1; in_opcode = OPL; in_funct3 = 3'b011; in_result = 64'hA000;
        in_rd = 5'd4; dresp_data = 64'h55;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_dreq_before", {63'd0, dreq_valid}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_dreq_dropped", {63'd0, dreq_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        dresp_ok = 1'b1;
        @(negedge clk);
        dresp_ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rst_no_out", {61'd0, out_valid, dreq_valid, in_ready}, 64'd1);
            @(negedge clk);
        end
        chk("rst_out_data", out_data, 64'd0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Downstream neighbour of the execute ALU.
- Consumes the ALU Result either as an effective address (loads/stores) or as a pass-through value (all other ops).
- Issues one data-bus transaction per load/store, aligns store data and byte strobes, and sign/zero-extends load data.
- Hands a single writeback record to the register-write stage over a valid/ready handshake.

Parameters:
XLEN, 64, datapath and address width
REG_AW, 5, register index width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  ALU result valid
in_ready  output  1  block can accept a new op
in_opcode  input  7  instr[6:0] of the op
in_funct3  input  3  instr[14:12] of the op
in_result  input  XLEN  ALU Result (address or value)
in_store_data  input  XLEN  rs2 value for stores
in_rd  input  REG_AW  destination register
dreq_valid  output  1  bus request valid
dreq_write  output  1  1 = store, 0 = load
dreq_addr  output  XLEN  unaligned byte address
dreq_size  output  3  0=1B, 1=2B, 2=4B, 3=8B
dreq_strobe  output  8  byte enables
dreq_data  output  XLEN  lane-shifted store data
dresp_ok  input  1  bus response; valid for exactly one cycle
dresp_data  input  XLEN  8-byte-aligned load data
out_valid  output  1  writeback record valid
out_ready  input  1  writeback stage accepts
out_rd  output  REG_AW  destination register
out_wen  output  1  register write enable
out_data  output  XLEN  writeback value
out_misalign  output  1  misaligned access flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0 except in_ready=1. An outstanding request is abandoned.
- In IDLE, dresp_ok is ignored.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch opcode/funct3/result/store_data/rd.
    - Load (0000011) or store (0100011), aligned -> MEM.
    - Load or store, misaligned -> DONE with out_misalign=1, out_wen=0; no bus request is issued.
    - Any other opcode -> DONE with out_data=in_result, out_wen=(rd!=0).
  - MEM: dreq_valid=1; all dreq_* fields held stable from the latched values. When dresp_ok=1, capture the load result into out_data -> DONE. Wait for dresp_ok is unbounded.
  - DONE: out_valid=1 with out fields stable. When out_ready=1 -> IDLE next cycle. in_ready stays 0 in DONE, so a new op is never accepted in the same cycle as the handoff.
- Latency (in_valid accepted to out_valid):
  - Non-memory op: 1 cycle.
  - Memory op: 2 + bus wait cycles.
- Size decode (funct3[1:0]): size = funct3[1:0]. Misaligned when addr[2:0] & ((1<<size)-1) != 0.
- Store encoding:
  - off = addr[2:0].
  - dreq_strobe = ((1<<(1<<size))-1) << off, 8 bits.
  - dreq_data = store_data << (8*off).
  - out_wen=0.
- Load decode:
  - raw = dresp_data >> (8*off), truncated to 1<<size bytes.
  - funct3[2]=0: sign-extend (LB/LH/LW/LD).
  - funct3[2]=1: zero-extend (LBU/LHU/LWU).
  - funct3 111 on a load is illegal and is treated as LD with zero-extension.
  - out_wen=(rd!=0).
- rd=0: out_wen=0 on every path; a load still performs its bus access.
- Loads: dreq_strobe=0 and dreq_data=0.

Decomposition:
- Shared package mau_pkg:
  - Opcode constants OP_LOAD and OP_STORE.
  - funct3 constants LB..LWU and SB..SD.
  - msize_t enum (MSIZE1/2/4/8).
  - state_t enum (IDLE/MEM/DONE).
- One combinational sub-module, mem_lane_align:
  - Inputs: addr[2:0], size, store data, load data, funct3[2].
  - Outputs: strobe, shifted store data, extended load data.
- The FSM, latches and handshake stay in mem_access_unit.

Test Plan:
- Non-memory pass-through: opcode 0110011, result 0x1234, rd 5, out_ready=1 -> out_valid 1 cycle after accept; out_data=0x1234, out_wen=1; dreq_valid never asserted.
- LB from addr 0x1003, dresp_data 0x0000_0000_8000_0000 after 3 wait cycles -> dreq_size=0; out_data=0xFFFF_FFFF_FFFF_FF80. Same access as LBU -> out_data=0x80.
- SH to addr 0x2006, store_data 0xABCD -> dreq_strobe=0xC0, dreq_data=0xABCD_0000_0000_0000, dreq_write=1; out_wen=0 after dresp_ok.
- LW to addr 0x3002 -> no dreq_valid; out_valid with out_misalign=1 and out_wen=0, 1 cycle after accept.
- Back-pressure: LD completes while out_ready=0 for 4 cycles -> out fields stable and in_ready=0 throughout; IDLE in the cycle after out_ready=1.
- Reset mid-MEM: assert reset while dreq_valid=1 -> dreq_valid=0 immediately; a later dresp_ok is ignored, and no out_valid appears.
